// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller:
// states, opcodes, funct codes, ALU ops and mux selects.
package mcpu_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EXE = 3'b010,
      S_MEM = 3'b011,
      S_WB  = 3'b100
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_SLT = 4'b1011;
   localparam logic [3:0] ALU_LUI = 4'b0110;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_RS  = 2'b10;
   localparam logic [1:0] PC_JMP = 2'b11;

   localparam logic [1:0] B_RT  = 2'b00;
   localparam logic [1:0] B_4   = 2'b01;
   localparam logic [1:0] B_IMM = 2'b10;
   localparam logic [1:0] B_BR  = 2'b11;

   typedef struct packed {
      logic rtype;
      logic ialu;
      logic lw;
      logic sw;
      logic br;
      logic j;
      logic jal;
      logic jr;
      logic illegal;
   } iclass_t;

   function automatic logic [3:0] alu_r(input logic [5:0] f);
      case (f)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic [3:0] alu_i(input logic [5:0] o);
      case (o)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_LUI:  return ALU_LUI;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mcycle_decode.sv
// Opcode/funct to one-hot instruction class.
// Anything not recognised is flagged illegal.
module mcycle_decode
   import mcpu_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output iclass_t    cls
);

   // classify the instruction held in the IR
   always_comb begin
      cls = '0;
      case (op)
         OP_R: begin
            case (func)
               FN_ADD, FN_SUB, FN_AND,
               FN_OR, FN_SLT: cls.rtype = 1'b1;
               FN_JR:         cls.jr = 1'b1;
               default:       cls.illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ANDI,
         OP_ORI, OP_LUI:  cls.ialu = 1'b1;
         OP_LW:           cls.lw = 1'b1;
         OP_SW:           cls.sw = 1'b1;
         OP_BEQ, OP_BNE:  cls.br = 1'b1;
         OP_J:            cls.j = 1'b1;
         OP_JAL:          cls.jal = 1'b1;
         default:         cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle CPU control FSM: IF/ID/EXE/MEM/WB
// sequencing and per-state datapath control.
module mcycle_ctrl
   import mcpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       zero,
   output logic       wpc,
   output logic       wir,
   output logic       wmem,
   output logic       wreg,
   output logic       iord,
   output logic [1:0] pcsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluc,
   output logic       sext,
   output logic       m2reg,
   output logic       regrt,
   output logic       jal,
   output logic [2:0] state
);

   state_t  st, nxt;
   iclass_t cls;
   logic    wpc_c, wir_c, wmem_c, wreg_c;

   mcycle_decode u_dec (
      .op   (op),
      .func (func),
      .cls  (cls)
   );

   // state register; reset wins over any transition
   always_ff @(posedge clk) begin
      if (rst) st <= S_IF;
      else     st <= nxt;
   end

   // next state and control outputs for the current state
   always_comb begin
      nxt     = S_IF;
      wpc_c   = 1'b0;
      wir_c   = 1'b0;
      wmem_c  = 1'b0;
      wreg_c  = 1'b0;
      iord    = 1'b0;
      pcsrc   = PC_SEQ;
      alusrca = 1'b0;
      alusrcb = B_RT;
      aluc    = ALU_ADD;
      sext    = 1'b0;
      m2reg   = 1'b0;
      regrt   = 1'b0;
      jal     = 1'b0;
      case (st)
         S_IF: begin
            wir_c   = 1'b1;
            wpc_c   = 1'b1;
            alusrcb = B_4;
            nxt     = S_ID;
         end
         S_ID: begin
            alusrcb = B_BR;
            nxt     = S_EXE;
            unique case (1'b1)
               cls.j: begin
                  wpc_c = 1'b1;
                  pcsrc = PC_JMP;
                  nxt   = S_IF;
               end
               cls.jal: begin
                  wpc_c  = 1'b1;
                  pcsrc  = PC_JMP;
                  wreg_c = 1'b1;
                  jal    = 1'b1;
                  nxt    = S_IF;
               end
               cls.jr: begin
                  wpc_c = 1'b1;
                  pcsrc = PC_RS;
                  nxt   = S_IF;
               end
               cls.illegal: nxt = S_IF;
               default: ;
            endcase
         end
         S_EXE: begin
            alusrca = 1'b1;
            unique case (1'b1)
               cls.rtype: begin
                  aluc = alu_r(func);
                  nxt  = S_WB;
               end
               cls.ialu: begin
                  alusrcb = B_IMM;
                  sext    = (op == OP_ADDI);
                  aluc    = alu_i(op);
                  nxt     = S_WB;
               end
               cls.lw, cls.sw: begin
                  alusrcb = B_IMM;
                  sext    = 1'b1;
                  nxt     = S_MEM;
               end
               cls.br: begin
                  aluc  = ALU_SUB;
                  pcsrc = PC_BR;
                  wpc_c = op[0] ? ~zero : zero;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            iord = 1'b1;
            if (cls.sw) wmem_c = 1'b1;
            if (cls.lw) nxt = S_WB;
         end
         S_WB: begin
            wreg_c = 1'b1;
            iord   = cls.lw;
            m2reg  = cls.lw;
            regrt  = cls.lw | cls.ialu;
         end
         default: ;
      endcase
   end

   assign wpc   = wpc_c & ~rst;
   assign wir   = wir_c & ~rst;
   assign wmem  = wmem_c & ~rst;
   assign wreg  = wreg_c & ~rst;
   assign state = st;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed vector bench for mcycle_ctrl: one table
// row per clock cycle, plus a hand-written reset sequence.
module tb_mcycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] func;
   logic       zero;
   logic       wpc, wir, wmem, wreg, iord;
   logic [1:0] pcsrc;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [3:0] aluc;
   logic       sext, m2reg, regrt, jal;
   logic [2:0] state;

   int nvec = 0;
   int nerr = 0;

   mcycle_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .op      (op),
      .func    (func),
      .zero    (zero),
      .wpc     (wpc),
      .wir     (wir),
      .wmem    (wmem),
      .wreg    (wreg),
      .iord    (iord),
      .pcsrc   (pcsrc),
      .alusrca (alusrca),
      .alusrcb (alusrcb),
      .aluc    (aluc),
      .sext    (sext),
      .m2reg   (m2reg),
      .regrt   (regrt),
      .jal     (jal),
      .state   (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [5:0]  o;
      logic [5:0]  f;
      logic        z;
      logic [20:0] e;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   // packed expectation: state, {wpc,wir,wmem,wreg},
   // iord, pcsrc, alusrca, alusrcb, aluc,
   // {sext,m2reg,regrt}, jal
   function automatic logic [20:0] x(
      input logic [2:0] s, input logic [3:0] en,
      input logic io, input logic [1:0] pc,
      input logic a, input logic [1:0] b,
      input logic [3:0] al, input logic [2:0] fl,
      input logic jl);
      return {s, en, io, pc, a, b, al, fl, jl};
   endfunction

   function automatic logic [20:0] act();
      return {state, wpc, wir, wmem, wreg, iord, pcsrc,
              alusrca, alusrcb, aluc, sext, m2reg, regrt, jal};
   endfunction

   function automatic logic [20:0] x_if();
      return x(3'd0, 4'b1100, 0, 2'b00, 0, 2'b01,
               4'b0000, 3'b000, 0);
   endfunction

   function automatic logic [20:0] x_id();
      return x(3'd1, 4'b0000, 0, 2'b00, 0, 2'b11,
               4'b0000, 3'b000, 0);
   endfunction

   task automatic add(input logic r, input logic [5:0] o,
                      input logic [5:0] f, input logic z,
                      input logic [20:0] e, input string nm);
      vec_t v;
      v.r = r; v.o = o; v.f = f; v.z = z; v.e = e; v.nm = nm;
      tbl.push_back(v);
   endtask

   // apply inputs after the falling edge, check mid-cycle
   task automatic step(input logic r, input logic [5:0] o,
                       input logic [5:0] f, input logic z,
                       input logic [20:0] e, input string nm);
      rst = r; op = o; func = f; zero = z;
      #2;
      nvec++;
      if (act() !== e) begin
         nerr++;
         $display("FAIL %s: got %b want %b", nm, act(), e);
      end
      @(negedge clk);
   endtask

   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] BNE = 6'b000101;
   localparam logic [5:0] JAL = 6'b000011;
   localparam logic [5:0] JJ  = 6'b000010;
   localparam logic [5:0] ORI = 6'b001101;
   localparam logic [5:0] BAD = 6'b111111;

   initial begin
      rst = 1'b1; op = LW; func = '0; zero = 1'b0;
      @(negedge clk);
      @(negedge clk);

      add(1, LW, 0, 0, x(3'd0, 4'b0000, 0, 2'b00, 0,
          2'b01, 4'b0000, 3'b000, 0), "rst_hold");
      add(0, LW, 0, 0, x_if(), "lw_if");
      add(0, LW, 0, 0, x_id(), "lw_id");
      add(0, LW, 0, 0, x(3'd2, 4'b0000, 0, 2'b00, 1,
          2'b10, 4'b0000, 3'b100, 0), "lw_exe");
      add(0, LW, 0, 0, x(3'd3, 4'b0000, 1, 2'b00, 0,
          2'b00, 4'b0000, 3'b000, 0), "lw_mem");
      add(0, LW, 0, 0, x(3'd4, 4'b0001, 1, 2'b00, 0,
          2'b00, 4'b0000, 3'b011, 0), "lw_wb");
      add(0, BEQ, 0, 1, x_if(), "beq1_if");
      add(0, BEQ, 0, 1, x_id(), "beq1_id");
      add(0, BEQ, 0, 1, x(3'd2, 4'b1000, 0, 2'b01, 1,
          2'b00, 4'b0100, 3'b000, 0), "beq1_exe");
      add(0, BEQ, 0, 0, x_if(), "beq0_if");
      add(0, BEQ, 0, 0, x_id(), "beq0_id");
      add(0, BEQ, 0, 0, x(3'd2, 4'b0000, 0, 2'b01, 1,
          2'b00, 4'b0100, 3'b000, 0), "beq0_exe");
      add(0, BNE, 0, 0, x_if(), "bne_if");
      add(0, BNE, 0, 0, x_id(), "bne_id");
      add(0, BNE, 0, 0, x(3'd2, 4'b1000, 0, 2'b01, 1,
          2'b00, 4'b0100, 3'b000, 0), "bne_exe");
      add(0, JAL, 0, 0, x_if(), "jal_if");
      add(0, JAL, 0, 0, x(3'd1, 4'b1001, 0, 2'b11, 0,
          2'b11, 4'b0000, 3'b000, 1), "jal_id");
      add(0, JJ, 0, 0, x_if(), "j_if");
      add(0, JJ, 0, 0, x(3'd1, 4'b1000, 0, 2'b11, 0,
          2'b11, 4'b0000, 3'b000, 0), "j_id");
      add(0, 0, 6'b001000, 0, x_if(), "jr_if");
      add(0, 0, 6'b001000, 0, x(3'd1, 4'b1000, 0, 2'b10,
          0, 2'b11, 4'b0000, 3'b000, 0), "jr_id");
      add(0, 0, 6'b100010, 0, x_if(), "sub_if");
      add(0, 0, 6'b100010, 0, x_id(), "sub_id");
      add(0, 0, 6'b100010, 0, x(3'd2, 4'b0000, 0, 2'b00,
          1, 2'b00, 4'b0100, 3'b000, 0), "sub_exe");
      add(0, 0, 6'b100010, 0, x(3'd4, 4'b0001, 0, 2'b00,
          0, 2'b00, 4'b0000, 3'b000, 0), "sub_wb");
      add(0, 0, 6'b101010, 0, x_if(), "slt_if");
      add(0, 0, 6'b101010, 0, x_id(), "slt_id");
      add(0, 0, 6'b101010, 0, x(3'd2, 4'b0000, 0, 2'b00,
          1, 2'b00, 4'b1011, 3'b000, 0), "slt_exe");
      add(0, 0, 6'b101010, 0, x(3'd4, 4'b0001, 0, 2'b00,
          0, 2'b00, 4'b0000, 3'b000, 0), "slt_wb");
      add(0, ORI, 0, 0, x_if(), "ori_if");
      add(0, ORI, 0, 0, x_id(), "ori_id");
      add(0, ORI, 0, 0, x(3'd2, 4'b0000, 0, 2'b00, 1,
          2'b10, 4'b0101, 3'b000, 0), "ori_exe");
      add(0, ORI, 0, 0, x(3'd4, 4'b0001, 0, 2'b00, 0,
          2'b00, 4'b0000, 3'b001, 0), "ori_wb");
      add(0, SW, 0, 0, x_if(), "sw_if");
      add(0, SW, 0, 0, x_id(), "sw_id");
      add(0, SW, 0, 0, x(3'd2, 4'b0000, 0, 2'b00, 1,
          2'b10, 4'b0000, 3'b100, 0), "sw_exe");
      add(0, SW, 0, 0, x(3'd3, 4'b0010, 1, 2'b00, 0,
          2'b00, 4'b0000, 3'b000, 0), "sw_mem");
      add(0, BAD, 0, 0, x_if(), "bad_if");
      add(0, BAD, 0, 0, x_id(), "bad_id");
      add(0, 0, 6'b111111, 0, x_if(), "badfn_if");
      add(0, 0, 6'b111111, 0, x_id(), "badfn_id");
      add(0, LW, 0, 0, x_if(), "after_bad_if");

      foreach (tbl[i])
         step(tbl[i].r, tbl[i].o, tbl[i].f, tbl[i].z,
              tbl[i].e, tbl[i].nm);

      // reset asserted for two cycles in the middle of lw
      step(0, LW, 0, 0, x_id(), "mr_id");
      step(1, LW, 0, 0, x(3'd2, 4'b0000, 0, 2'b00, 1,
           2'b10, 4'b0000, 3'b100, 0), "mr_exe_rst");
      step(1, LW, 0, 0, x(3'd0, 4'b0000, 0, 2'b00, 0,
           2'b01, 4'b0000, 3'b000, 0), "mr_if_rst");
      step(0, LW, 0, 0, x_if(), "mr_release_if");
      step(0, LW, 0, 0, x_id(), "mr_id2");

      // reset during IF must squash the fetch enables
      step(1, LW, 0, 0, x(3'd2, 4'b0000, 0, 2'b00, 1,
           2'b10, 4'b0000, 3'b100, 0), "exe_rst2");
      step(1, LW, 0, 0, x(3'd0, 4'b0000, 0, 2'b00, 0,
           2'b01, 4'b0000, 3'b000, 0), "if_rst2");
      step(0, LW, 0, 0, x_if(), "if_rel2");

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
